// File: rtl/package_sequencer.sv
// Frames one detector package into the downstream FIFO: header word, ENERGY_WORDS
// energy words, then a trailer carrying the bad-word flag and the word count.
module package_sequencer #(
  parameter int ENERGY_WORDS   = 1024,
  parameter int PACKAGE_LENGTH = 1036
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        live_rising,
  input  logic        get_package,
  input  logic [15:0] r_pkglength,
  input  logic [13:0] r_evtno,
  input  logic [15:0] data_in,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        pkg_done,
  output logic        pkg_err,
  output logic [2:0]  err_code,
  output logic [15:0] evt_cnt,
  output logic [15:0] drop_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, CAPTURE, TRAILER, DONE} state_t;

  localparam logic [15:0] PKG_LEN = 16'(PACKAGE_LENGTH);
  localparam logic [12:0] WC_LAST = 13'(ENERGY_WORDS - 1);

  state_t      state_q, state_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        pkg_done_q, pkg_done_d;
  logic        pkg_err_q, pkg_err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [15:0] evt_cnt_q, evt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [12:0] word_cnt_q, word_cnt_d;
  logic        bad_flag_q, bad_flag_d;
  logic        take_hdr;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  // An abort followed by a rejected header in the same cycle drops two packages.
  assign drop_sum = {1'b0, drop_cnt_q} + {15'b0, drop_inc};

  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    pkg_done_d = 1'b0;
    pkg_err_d  = 1'b0;
    err_code_d = err_code_q;
    evt_cnt_d  = evt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    word_cnt_d = word_cnt_q;
    bad_flag_d = bad_flag_q;
    take_hdr   = 1'b0;
    drop_inc   = 2'd0;

    if (live_rising) begin
      state_d    = IDLE;
      err_code_d = 3'd0;
      evt_cnt_d  = 16'd0;
      drop_cnt_d = 16'd0;
      word_cnt_d = 13'd0;
      bad_flag_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: take_hdr = get_package;
        CAPTURE, TRAILER: begin
          if (get_package) begin
            pkg_err_d  = 1'b1;
            err_code_d = 3'd4;
            drop_inc   = 2'd1;
            state_d    = IDLE;
            take_hdr   = 1'b1;
          end else if (fifo_full) begin
            pkg_err_d  = 1'b1;
            err_code_d = 3'd3;
            drop_inc   = 2'd1;
            state_d    = IDLE;
          end else if (state_q == CAPTURE) begin
            wr_en_d    = 1'b1;
            wr_data_d  = data_in;
            word_cnt_d = word_cnt_q + 13'd1;
            bad_flag_d = bad_flag_q | (data_in[15:14] != 2'b10);
            if (word_cnt_q == WC_LAST) state_d = TRAILER;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = {2'b01, bad_flag_q, word_cnt_q};
            state_d   = DONE;
          end
        end
        DONE: begin
          pkg_done_d = 1'b1;
          if (evt_cnt_q != 16'hFFFF) evt_cnt_d = evt_cnt_q + 16'd1;
          if (bad_flag_q) begin
            pkg_err_d  = 1'b1;
            err_code_d = 3'd5;
          end
          state_d  = IDLE;
          take_hdr = get_package;
        end
        default: state_d = IDLE;
      endcase

      // New header evaluation; its error cause overrides any earlier one this cycle.
      if (take_hdr) begin
        if (r_pkglength != PKG_LEN) begin
          pkg_err_d  = 1'b1;
          err_code_d = 3'd1;
          drop_inc   = drop_inc + 2'd1;
          state_d    = IDLE;
        end else if (fifo_full) begin
          pkg_err_d  = 1'b1;
          err_code_d = 3'd2;
          drop_inc   = drop_inc + 2'd1;
          state_d    = IDLE;
        end else begin
          state_d    = CAPTURE;
          wr_en_d    = 1'b1;
          wr_data_d  = {2'b11, r_evtno};
          word_cnt_d = 13'd0;
          bad_flag_d = 1'b0;
        end
      end
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 16'd0;
      busy_q     <= 1'b0;
      pkg_done_q <= 1'b0;
      pkg_err_q  <= 1'b0;
      err_code_q <= 3'd0;
      evt_cnt_q  <= 16'd0;
      drop_cnt_q <= 16'd0;
      word_cnt_q <= 13'd0;
      bad_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      pkg_done_q <= pkg_done_d;
      pkg_err_q  <= pkg_err_d;
      err_code_q <= err_code_d;
      evt_cnt_q  <= evt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      word_cnt_q <= word_cnt_d;
      bad_flag_q <= bad_flag_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign pkg_done  = pkg_done_q;
  assign pkg_err   = pkg_err_q;
  assign err_code  = err_code_q;
  assign evt_cnt   = evt_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign state_dbg = state_q;

endmodule
